// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: segment bit positions and the hex encode patterns (abcdefg order).
package sevenseg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] PAT_0 = 7'b1111110;
    localparam logic [6:0] PAT_1 = 7'b0110000;
    localparam logic [6:0] PAT_2 = 7'b1101101;
    localparam logic [6:0] PAT_3 = 7'b1111001;
    localparam logic [6:0] PAT_4 = 7'b0110011;
    localparam logic [6:0] PAT_5 = 7'b1011011;
    localparam logic [6:0] PAT_6 = 7'b1011111;
    localparam logic [6:0] PAT_7 = 7'b1110000;
    localparam logic [6:0] PAT_8 = 7'b1111111;
    localparam logic [6:0] PAT_9 = 7'b1111011;
    localparam logic [6:0] PAT_A = 7'b1110111;
    localparam logic [6:0] PAT_B = 7'b0011111;
    localparam logic [6:0] PAT_C = 7'b1001110;
    localparam logic [6:0] PAT_D = 7'b0111101;
    localparam logic [6:0] PAT_E = 7'b1001111;
    localparam logic [6:0] PAT_F = 7'b1000111;

    // Some drivers render 9 without the bottom segment.
    localparam logic [6:0] PAT_9_ALT = 7'b1110011;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns flag err and return 0.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       err
);

    always_comb begin
        nib = 4'h0;
        err = 1'b0;
        case (pat)
            PAT_0:     nib = 4'h0;
            PAT_1:     nib = 4'h1;
            PAT_2:     nib = 4'h2;
            PAT_3:     nib = 4'h3;
            PAT_4:     nib = 4'h4;
            PAT_5:     nib = 4'h5;
            PAT_6:     nib = 4'h6;
            PAT_7:     nib = 4'h7;
            PAT_8:     nib = 4'h8;
            PAT_9:     nib = 4'h9;
            PAT_9_ALT: nib = 4'h9;
            PAT_A:     nib = 4'hA;
            PAT_B:     nib = 4'hB;
            PAT_C:     nib = 4'hC;
            PAT_D:     nib = 4'hD;
            PAT_E:     nib = 4'hE;
            PAT_F:     nib = 4'hF;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Samples a multiplexed seven-segment bus, debounces each digit and emits one hex value per scan frame.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig,
    output logic [4*NUM_DIGITS-1:0] out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

    logic [6:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       dig_q;
    logic [CNT_W-1:0]            cnt;
    logic [NUM_DIGITS-1:0][3:0]  nib_q, nib_next;
    logic [NUM_DIGITS-1:0]       mask_q, mask_next;
    logic [NUM_DIGITS-1:0]       err_q, err_next;
    logic                        dig_onehot, same, capture, frame_done;
    logic [3:0]                  dec_nib;
    logic                        dec_err;

    sevenseg_pattern_decode u_dec (
        .pat (seg_q),
        .nib (dec_nib),
        .err (dec_err)
    );

    assign dig_onehot = (dig_q != '0) && ((dig_q & (dig_q - DIG_ONE)) == '0);
    assign same       = (seg == seg_q) && (dig == dig_q);
    // Fires only on the LAST->MAX step, so a long hold captures once.
    assign capture    = same && dig_onehot && (cnt == CNT_LAST);

    always_comb begin
        nib_next  = nib_q;
        mask_next = mask_q;
        err_next  = err_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_q[i]) begin
                    nib_next[i]  = dec_nib;
                    err_next[i]  = dec_err;
                    mask_next[i] = 1'b1;
                end
            end
        end
    end

    assign frame_done = capture && (&mask_next);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q     <= '0;
            dig_q     <= '0;
            cnt       <= '0;
            nib_q     <= '0;
            mask_q    <= '0;
            err_q     <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_q <= seg;
            dig_q <= dig;
            if (same && dig_onehot) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNT_ONE;
            end else begin
                cnt <= '0;
            end
            nib_q <= nib_next;
            if (frame_done) begin
                mask_q <= '0;
                err_q  <= '0;
                if (!out_valid || out_ready) begin
                    out_data  <= nib_next;
                    out_err   <= |err_next;
                    out_valid <= 1'b1;
                end else begin
                    // Pending result is kept intact; the new frame is lost.
                    overrun <= 1'b1;
                end
            end else begin
                mask_q <= mask_next;
                err_q  <= err_next;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with a run-length based reference model checked every cycle.
module tb_sevenseg_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] ENC [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    localparam logic [6:0] ALT9 = 7'h73;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg;
    logic [ND-1:0] dig;
    logic [15:0]   out_data;
    logic          out_err, out_valid, out_ready, overrun;

    always #5 clk = ~clk;

    sevenseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig       (dig),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: a digit is taken when the same one-hot sample has been seen SC+1 times in a row.
    logic [6:0]    m_prev_seg;
    logic [ND-1:0] m_prev_dig;
    int            m_run;
    logic [3:0]    m_nib [ND];
    bit            m_errb [ND];
    bit            m_mask [ND];
    logic [15:0]   m_data;
    bit            m_err, m_valid, m_ovr;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_prev_seg = '0; m_prev_dig = '0; m_run = 0;
            m_data = '0; m_err = 0; m_valid = 0; m_ovr = 0;
            for (int i = 0; i < ND; i++) begin
                m_nib[i] = '0; m_errb[i] = 0; m_mask[i] = 0;
            end
        end else begin
            bit onehot, done;
            onehot = ($countones(dig) == 1);
            if (!onehot)
                m_run = 0;
            else if (seg == m_prev_seg && dig == m_prev_dig)
                m_run++;
            else
                m_run = 1;
            done = 0;
            if (m_run == SC + 1) begin
                logic [3:0] v;
                bit e;
                int idx;
                v = 4'h0; e = 1; idx = 0;
                for (int k = 0; k < 16; k++)
                    if (seg == ENC[k]) begin v = 4'(k); e = 0; end
                if (seg == ALT9) begin v = 4'h9; e = 0; end
                for (int i = 0; i < ND; i++) if (dig[i]) idx = i;
                m_nib[idx] = v; m_errb[idx] = e; m_mask[idx] = 1;
                done = 1;
                for (int i = 0; i < ND; i++) if (!m_mask[i]) done = 0;
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_err = 0;
                    for (int i = 0; i < ND; i++) begin
                        m_data[4*i +: 4] = m_nib[i];
                        m_err = m_err | m_errb[i];
                    end
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
                for (int i = 0; i < ND; i++) begin m_mask[i] = 0; m_errb[i] = 0; end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            m_prev_seg = seg;
            m_prev_dig = dig;
        end
    end

    // Per-cycle compare plus a rise monitor used by the literal checks.
    int          cyc = 0, rises = 0, rise_cyc = 0;
    logic [15:0] rise_data;
    logic        rise_err;
    logic        ov_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        chk("cyc_out_data", out_data, m_data);
        chk("cyc_out_err", out_err, m_err);
        chk("cyc_out_valid", out_valid, m_valid);
        chk("cyc_overrun", overrun, m_ovr);
        if (out_valid && !ov_prev) begin
            rises++;
            rise_cyc  = cyc;
            rise_data = out_data;
            rise_err  = out_err;
        end
        ov_prev = out_valid;
    end

    task automatic hold(input logic [6:0] s, input logic [ND-1:0] d, input int n);
        seg = s;
        dig = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [3:0] n0, n1, n2, n3);
        hold(ENC[n0], 4'b0001, 8);
        hold(ENC[n1], 4'b0010, 8);
        hold(ENC[n2], 4'b0100, 8);
        hold(ENC[n3], 4'b1000, 8);
    endtask

    initial begin
        int r0, c0;
        rst_n = 1'b0; seg = '0; dig = '0; out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            seg = 7'($urandom); dig = 4'($urandom);
            @(negedge clk);
        end
        chk("rst_data", out_data, 16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_err", out_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        hold(7'h00, 4'b0000, 3);
        chk("rst_no_valid", rises, 0);

        // basic frame, latency of the final digit
        r0 = rises;
        hold(ENC[4], 4'b0001, 8);
        hold(ENC[3], 4'b0010, 8);
        hold(ENC[2], 4'b0100, 8);
        c0 = cyc;
        hold(ENC[1], 4'b1000, 8);
        chk("basic_rises", rises - r0, 1);
        chk("basic_latency", rise_cyc - c0, SC + 1);
        chk("basic_data", rise_data, 16'h1234);
        chk("basic_err", rise_err, 1'b0);
        chk("basic_pulse", out_valid, 1'b0);

        // glitch filter: short holds and a multi-hot enable
        r0 = rises;
        for (int i = 0; i < ND; i++) hold(ENC[i + 5], 4'(1 << i), 3);
        hold(ENC[7], 4'b0011, 8);
        hold(7'h00, 4'b0000, 2);
        chk("glitch_none", rises - r0, 0);
        frame(4'hA, 4'hB, 4'hC, 4'hD);
        chk("glitch_rises", rises - r0, 1);
        chk("glitch_data", rise_data, 16'hDCBA);

        // invalid pattern plus alternate 9
        hold(7'b0000001, 4'b0001, 8);
        hold(ALT9, 4'b0010, 8);
        hold(ENC[0], 4'b0100, 8);
        hold(ENC[0], 4'b1000, 8);
        chk("inv_data", rise_data, 16'h0090);
        chk("inv_err", rise_err, 1'b1);

        // backpressure and overrun
        out_ready = 1'b0;
        frame(4'h1, 4'h1, 4'h1, 4'h1);
        frame(4'h2, 4'h2, 4'h2, 4'h2);
        hold(7'h00, 4'b0000, 2);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_data", out_data, 16'h1111);
        chk("bp_overrun", overrun, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", out_valid, 1'b0);
        chk("bp_sticky", overrun, 1'b1);

        // reset in the middle of a frame
        hold(ENC[15], 4'b0001, 8);
        hold(ENC[14], 4'b0010, 8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rises;
        frame(4'h8, 4'h7, 4'h6, 4'h5);
        hold(7'h00, 4'b0000, 4);
        chk("mrst_rises", rises - r0, 1);
        chk("mrst_data", rise_data, 16'h5678);
        chk("mrst_err", rise_err, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Reverse path of the segment decoder: samples a multiplexed seven-segment display bus (segments a..g plus one-hot digit enables) and recovers the displayed hex value.
- Filters ghosting and transitions with a stability counter.
- Assembles one value per complete scan frame and hands it downstream over a valid/ready handshake.
- Used for display loopback checking and for snooping legacy display drivers.

Parameters:
- NUM_DIGITS, 4: digit positions per frame; out_data width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (min 2).
- CNT_W, 3: stability counter width; must hold STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- seg  in  7  segment levels, 1 = lit; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
- dig  in  NUM_DIGITS  digit enables, active-high, one-hot while a digit is driven; bit 0 = rightmost digit.
- out_data  out  4*NUM_DIGITS  recovered value; nibble i = digit i.
- out_err  out  1  at least one digit in this frame had an undecodable pattern (that nibble reads 0).
- out_valid  out  1  out_data/out_err are valid.
- out_ready  in  1  downstream accept.
- overrun  out  1  sticky: a completed frame was dropped because the output was still pending.

Behaviour:
- One clock, reset is synchronous and active-low: all state updates only on the rising clk edge, and rst_n is sampled only there.
- Reset values: out_data=0, out_err=0, out_valid=0, overrun=0, capture mask=0, stability counter=0, sample registers=0. Reset mid-frame discards all partial captures.
- Inputs are registered once (seg_q, dig_q) before any comparison.
- Stability counter rules:
  - (seg, dig) equals (seg_q, dig_q) and dig_q is one-hot: counter increments, saturating at STABLE_CYCLES.
  - Any change, dig all-zero (blanking), or dig not one-hot: counter clears.
- Capture fires exactly once per stable interval, on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. Net effect: a digit is captured STABLE_CYCLES+1 edges after its first appearance on the inputs.
- On capture:
  - Decode seg_q to a nibble and write it to the position selected by dig_q.
  - Set that mask bit and record that position's error bit.
  - A position already set in the mask is overwritten; latest value wins.
- Decode table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011 or 1110011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern, including all-off, sets that position's error bit and writes nibble 0.
- Frame completion is the capture edge that makes the mask all-ones. On that same edge:
  - If out_valid=0, or out_valid=1 with out_ready=1: load out_data and out_err (OR of the position error bits), assert out_valid, clear the mask and error bits.
  - If out_valid=1 and out_ready=0: drop the frame, set overrun, clear the mask and error bits; out_data stays stable.
- Handshake:
  - out_valid stays high, with out_data/out_err stable, until an edge with out_ready=1.
  - On that edge out_valid drops, unless a new frame completes on the same edge. In that case the new data loads and out_valid stays 1.
- overrun clears only on reset.
- Scan order is irrelevant; frames need not be contiguous in time.

Decomposition:
- Shared package sevenseg_pkg holds:
  - segment bit-index constants SEG_A..SEG_G;
  - the 16 encode patterns as localparams, shared with the existing decoder;
  - the alternate 9 pattern.
- One sub-module, sevenseg_pattern_decode: combinational 7-bit in, 4-bit nibble plus err out. The top holds the sampler, stability counter, capture mask and output handshake.

Test Plan:
- Reset: hold rst_n=0 over 3 edges with activity on seg/dig -> all outputs 0; release, no out_valid until a full frame is scanned.
- Basic frame: scan dig=0001,0010,0100,1000 with patterns for 4,3,2,1, each held 8 cycles, out_ready=1 -> out_valid pulses 1 cycle, out_data=16'h1234, out_err=0. Check the first capture STABLE_CYCLES+1 edges after dig=0001 appears.
- Glitch filter: hold each digit only 3 cycles (< STABLE_CYCLES+1), or insert non-one-hot dig=0011 -> no capture, out_valid never rises. Then 8-cycle holds of A,b,C,d (order 0..3) -> out_data=16'hDCBA.
- Invalid and alternate patterns: digit 0 = 0000001, digit 1 = 1110011, others 0 -> out_data=16'h0090, out_err=1.
- Backpressure/overrun: out_ready=0, scan two complete frames 16'h1111 then 16'h2222 -> out_data stays 16'h1111 and overrun=1. Raise out_ready -> out_valid drops after 1 edge; overrun stays 1.
- Mid-frame reset: capture 2 digits, pulse rst_n=0 for one edge, scan a full frame 16'h5678 -> single output 16'h5678, no stale nibbles.
